// File: rtl/hazard_stall_controller.sv
// ID-stage hazard unit: load-use stalls of configurable length, branch/jump flush,
// sticky HALT, and a saturating count of inserted load-use bubbles.
module hazard_stall_controller #(
    parameter int                  REG_ADDR_W        = 5,
    parameter int                  OPCODE_W          = 6,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE       = 6'b010101,
    parameter int                  LOAD_STALL_CYCLES = 1,
    parameter int                  STALL_CNT_W       = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [REG_ADDR_W-1:0]  I_HZ_ID_RS,
    input  logic [REG_ADDR_W-1:0]  I_HZ_ID_RT,
    input  logic                   I_HZ_ID_USES_RT,
    input  logic [OPCODE_W-1:0]    OPCODE,
    input  logic [REG_ADDR_W-1:0]  I_HZ_EXE_RT,
    input  logic                   I_HZ_EXE_MemRead,
    input  logic                   I_HZ_FLUSH,
    output logic                   O_HZ_PC_WRITE,
    output logic                   O_HZ_IFID_WRITE,
    output logic                   O_HZ_IFID_FLUSH,
    output logic                   O_HZ_ID_ControlMux,
    output logic                   O_HZ_HALTED,
    output logic [STALL_CNT_W-1:0] O_HZ_STALL_COUNT
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        HALTED     = 2'd2
    } state_t;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [2:0]             r_remain;
    logic [2:0]             w_next_remain;
    logic [STALL_CNT_W-1:0] r_stall_count;
    logic                   w_hazard;
    logic                   w_count_bubble;

    // Register 0 never carries a real dependency; RT only matters when ID reads it.
    assign w_hazard = I_HZ_EXE_MemRead && (I_HZ_EXE_RT != '0) &&
                      ((I_HZ_EXE_RT == I_HZ_ID_RS) ||
                       (I_HZ_ID_USES_RT && (I_HZ_EXE_RT == I_HZ_ID_RT)));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= RUN;
            r_remain      <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_remain <= w_next_remain;
            if (w_count_bubble && (r_stall_count != '1))
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_remain      = r_remain;
        w_count_bubble     = 1'b0;
        O_HZ_PC_WRITE      = 1'b1;
        O_HZ_IFID_WRITE    = 1'b1;
        O_HZ_IFID_FLUSH    = 1'b0;
        O_HZ_ID_ControlMux = 1'b0;
        if (!RESET) begin
            unique case (r_state)
                RUN: begin
                    // Flush wins: the ID instruction is wrong-path, so its hazard/HALT is moot.
                    if (I_HZ_FLUSH) begin
                        O_HZ_IFID_FLUSH    = 1'b1;
                        O_HZ_ID_ControlMux = 1'b1;
                    end else if (w_hazard) begin
                        O_HZ_PC_WRITE      = 1'b0;
                        O_HZ_IFID_WRITE    = 1'b0;
                        O_HZ_ID_ControlMux = 1'b1;
                        w_count_bubble     = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_state  = LOAD_STALL;
                            w_next_remain = STALL_RELOAD;
                        end
                    end else if (OPCODE == HALT_OPCODE) begin
                        O_HZ_PC_WRITE   = 1'b0;
                        O_HZ_IFID_WRITE = 1'b0;
                        w_next_state    = HALTED;
                    end
                end
                LOAD_STALL: begin
                    if (I_HZ_FLUSH) begin
                        O_HZ_IFID_FLUSH    = 1'b1;
                        O_HZ_ID_ControlMux = 1'b1;
                        w_next_remain      = '0;
                        w_next_state       = RUN;
                    end else begin
                        O_HZ_PC_WRITE      = 1'b0;
                        O_HZ_IFID_WRITE    = 1'b0;
                        O_HZ_ID_ControlMux = 1'b1;
                        w_count_bubble     = 1'b1;
                        w_next_remain      = r_remain - 3'd1;
                        if (r_remain == 3'd1)
                            w_next_state = RUN;
                    end
                end
                HALTED: begin
                    O_HZ_PC_WRITE      = 1'b0;
                    O_HZ_IFID_WRITE    = 1'b0;
                    O_HZ_ID_ControlMux = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    assign O_HZ_HALTED      = (r_state == HALTED);
    assign O_HZ_STALL_COUNT = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: four controller instances with different parameters share one
// input bus; each scenario resets them all and checks the instance it targets.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] idRs, idRt, exeRt;
    logic       usesRt, memRead, flush;
    logic [5:0] opcode;

    logic pcD, ifidD, flD, muxD, haltD;
    logic pc3, ifid3, fl3, mux3, halt3;
    logic pc4, ifid4, fl4, mux4, halt4;
    logic pcS, ifidS, flS, muxS, haltS;
    logic [15:0] cntD, cnt3, cnt4;
    logic [1:0]  cntS;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    hazard_stall_controller uD (
        .CLK(clk), .RESET(reset), .I_HZ_ID_RS(idRs), .I_HZ_ID_RT(idRt),
        .I_HZ_ID_USES_RT(usesRt), .OPCODE(opcode), .I_HZ_EXE_RT(exeRt),
        .I_HZ_EXE_MemRead(memRead), .I_HZ_FLUSH(flush),
        .O_HZ_PC_WRITE(pcD), .O_HZ_IFID_WRITE(ifidD), .O_HZ_IFID_FLUSH(flD),
        .O_HZ_ID_ControlMux(muxD), .O_HZ_HALTED(haltD), .O_HZ_STALL_COUNT(cntD));

    hazard_stall_controller #(.LOAD_STALL_CYCLES(3)) u3 (
        .CLK(clk), .RESET(reset), .I_HZ_ID_RS(idRs), .I_HZ_ID_RT(idRt),
        .I_HZ_ID_USES_RT(usesRt), .OPCODE(opcode), .I_HZ_EXE_RT(exeRt),
        .I_HZ_EXE_MemRead(memRead), .I_HZ_FLUSH(flush),
        .O_HZ_PC_WRITE(pc3), .O_HZ_IFID_WRITE(ifid3), .O_HZ_IFID_FLUSH(fl3),
        .O_HZ_ID_ControlMux(mux3), .O_HZ_HALTED(halt3), .O_HZ_STALL_COUNT(cnt3));

    hazard_stall_controller #(.LOAD_STALL_CYCLES(4)) u4 (
        .CLK(clk), .RESET(reset), .I_HZ_ID_RS(idRs), .I_HZ_ID_RT(idRt),
        .I_HZ_ID_USES_RT(usesRt), .OPCODE(opcode), .I_HZ_EXE_RT(exeRt),
        .I_HZ_EXE_MemRead(memRead), .I_HZ_FLUSH(flush),
        .O_HZ_PC_WRITE(pc4), .O_HZ_IFID_WRITE(ifid4), .O_HZ_IFID_FLUSH(fl4),
        .O_HZ_ID_ControlMux(mux4), .O_HZ_HALTED(halt4), .O_HZ_STALL_COUNT(cnt4));

    hazard_stall_controller #(.STALL_CNT_W(2)) uS (
        .CLK(clk), .RESET(reset), .I_HZ_ID_RS(idRs), .I_HZ_ID_RT(idRt),
        .I_HZ_ID_USES_RT(usesRt), .OPCODE(opcode), .I_HZ_EXE_RT(exeRt),
        .I_HZ_EXE_MemRead(memRead), .I_HZ_FLUSH(flush),
        .O_HZ_PC_WRITE(pcS), .O_HZ_IFID_WRITE(ifidS), .O_HZ_IFID_FLUSH(flS),
        .O_HZ_ID_ControlMux(muxS), .O_HZ_HALTED(haltS), .O_HZ_STALL_COUNT(cntS));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic ur, input logic [5:0] opc,
                                 input logic [4:0] ert, input logic mr,
                                 input logic fl);
        @(negedge clk);
        idRs = rs; idRt = rt; usesRt = ur; opcode = opc;
        exeRt = ert; memRead = mr; flush = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(5'd1, 5'd2, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Reset is held for one edge with a live hazard/HALT on the bus to show the override.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idRs = 5'd5; idRt = 5'd5; usesRt = 1'b1; opcode = 6'b010101;
        exeRt = 5'd5; memRead = 1'b1; flush = 1'b0;
        #1;
        checkOutput("resetForced", {pcD, ifidD, flD, muxD}, 4'b1100);
        @(negedge clk);
        reset = 1'b0;
        idRs = 5'd1; idRt = 5'd2; usesRt = 1'b1; opcode = 6'd0;
        exeRt = 5'd0; memRead = 1'b0; flush = 1'b0;
        #1;
        checkOutput("resetCount", cntD, 32'd0);
        checkOutput("resetHalted", haltD, 32'd0);
    endtask

    // {PC_WRITE, IFID_WRITE, IFID_FLUSH, ControlMux}
    localparam logic [3:0] NORMAL = 4'b1100;
    localparam logic [3:0] STALL  = 4'b0001;
    localparam logic [3:0] FLUSHO = 4'b1111;
    localparam logic [3:0] HALTIN = 4'b0000;

    initial begin
        reset = 1'b1;
        idRs = '0; idRt = '0; usesRt = 1'b0; opcode = '0;
        exeRt = '0; memRead = 1'b0; flush = 1'b0;
        doReset();

        // Single-cycle load-use stall on RS
        applyStimulus(5'd5, 5'd9, 1'b0, 6'd0, 5'd5, 1'b1, 1'b0);
        checkOutput("d1Stall", {pcD, ifidD, flD, muxD}, STALL);
        idle();
        checkOutput("d1After", {pcD, ifidD, flD, muxD}, NORMAL);
        checkOutput("d1Count", cntD, 32'd1);

        // Three-cycle stall on RT
        doReset();
        applyStimulus(5'd3, 5'd7, 1'b1, 6'd0, 5'd7, 1'b1, 1'b0);
        checkOutput("s3Cyc1", {pc3, ifid3, fl3, mux3}, STALL);
        idle();
        checkOutput("s3Cyc2", {pc3, ifid3, fl3, mux3}, STALL);
        checkOutput("s3DefCyc2", {pcD, ifidD, flD, muxD}, NORMAL);
        idle();
        checkOutput("s3Cyc3", {pc3, ifid3, fl3, mux3}, STALL);
        idle();
        checkOutput("s3Cyc4", {pc3, ifid3, fl3, mux3}, NORMAL);
        checkOutput("s3Count", cnt3, 32'd3);

        // Same match on RT but ID does not read RT
        doReset();
        applyStimulus(5'd3, 5'd7, 1'b0, 6'd0, 5'd7, 1'b1, 1'b0);
        checkOutput("noUsesRt", {pc3, ifid3, fl3, mux3}, NORMAL);
        idle();
        checkOutput("noUsesRtCnt", cnt3, 32'd0);

        // Register 0 never matches
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b1, 6'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("reg0", {pcD, ifidD, flD, muxD}, NORMAL);
        idle();
        checkOutput("reg0Cnt", cntD, 32'd0);

        // Flush in the second cycle of a four-cycle stall
        doReset();
        applyStimulus(5'd6, 5'd0, 1'b0, 6'd0, 5'd6, 1'b1, 1'b0);
        checkOutput("f4Cyc1", {pc4, ifid4, fl4, mux4}, STALL);
        applyStimulus(5'd1, 5'd2, 1'b1, 6'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("f4Flush", {pc4, ifid4, fl4, mux4}, FLUSHO);
        idle();
        checkOutput("f4After", {pc4, ifid4, fl4, mux4}, NORMAL);
        checkOutput("f4Count", cnt4, 32'd1);

        // Flush beats a simultaneous hazard and HALT in RUN
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b0, 6'b010101, 5'd5, 1'b1, 1'b1);
        checkOutput("flushPrio", {pcD, ifidD, flD, muxD}, FLUSHO);
        idle();
        checkOutput("flushPrioNext", {pcD, ifidD, flD, muxD, haltD}, {NORMAL, 1'b0});
        checkOutput("flushPrioCnt", cntD, 32'd0);

        // HALT is sticky until reset
        doReset();
        applyStimulus(5'd1, 5'd2, 1'b1, 6'b010101, 5'd0, 1'b0, 1'b0);
        checkOutput("haltEnter", {pcD, ifidD, flD, muxD}, HALTIN);
        checkOutput("haltNotYet", haltD, 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd4, 5'd4, 1'b1, 6'd0, 5'd4, i[0], i[1]);
            checkOutput("haltHeld", {pcD, ifidD, flD, muxD, haltD}, {STALL, 1'b1});
        end
        checkOutput("haltNoCount", cntD, 32'd0);
        doReset();
        checkOutput("haltExit", {pcD, ifidD, flD, muxD}, NORMAL);

        // Two-bit counter saturates at 3
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd8, 5'd0, 1'b0, 6'd0, 5'd8, 1'b1, 1'b0);
            checkOutput("satStall", {pcS, ifidS, flS, muxS}, STALL);
            idle();
            checkOutput("satCount", cntS, (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Hazard wins over HALT decode
        applyStimulus(5'd8, 5'd0, 1'b0, 6'b010101, 5'd8, 1'b1, 1'b0);
        checkOutput("hazOverHalt", {pcS, ifidS, flS, muxS}, STALL);
        idle();
        checkOutput("hazOverHaltNext", {pcS, ifidS, flS, muxS, haltS}, {NORMAL, 1'b0});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
